// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin grant, latched bus operands, and external
// transfers that finish on ext_ack or are aborted with err after TIMEOUT wait cycles.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr_rd0,
  input  logic          wr_rd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic          gnt0,
  output logic          gnt1,
  output logic          bus_valid,
  output logic          wr_rd,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] Data_BUS_WRITE,
  input  logic          ext_sel,
  input  logic          ext_ack
);

  // The counter only ever holds 0 .. TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_wr_q, bus_wr_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            err_q, err_d;
  logic            pick;
  logic            done;
  logic            timeout;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    pick        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the port not served last wins.
          pick        = (req0 && req1) ? ~last_q : req1;
          owner_d     = pick;
          last_d      = pick;
          cnt_d       = '0;
          bus_wr_d    = pick ? wr_rd1 : wr_rd0;
          bus_addr_d  = pick ? addr1 : addr0;
          bus_wdata_d = pick ? wdata1 : wdata0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (!ext_sel) begin
          done = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Timeout takes priority over a simultaneous ext_ack.
          done    = 1'b1;
          timeout = 1'b1;
        end else if (ext_ack) begin
          done = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (done) begin
          state_d = StDone;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          err_d   = timeout;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign gnt0           = (state_q != StIdle) && !owner_q;
  assign gnt1           = (state_q != StIdle) && owner_q;
  assign bus_valid      = (state_q == StBusy);
  assign wr_rd          = bus_wr_q;
  assign ADDR           = bus_addr_q;
  assign Data_BUS_WRITE = bus_wdata_q;
  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign err            = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, internal read, round-robin tie, external write,
// timeout (with and without a late ack), mid-transfer reset and operand stability.
module tb_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          req0, req1, wr_rd0, wr_rd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err, gnt0, gnt1, bus_valid, wr_rd;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] Data_BUS_WRITE;
  logic          ext_sel, ext_ack;

  int errors = 0;
  int checks = 0;

  // Control outputs packed as {gnt1, gnt0, bus_valid, ack1, ack0, err}.
  logic [5:0] ctl;
  assign ctl = {gnt1, gnt0, bus_valid, ack1, ack0, err};

  localparam logic [5:0] CtlIdle  = 6'b000000;
  localparam logic [5:0] CtlBusy0 = 6'b011000;
  localparam logic [5:0] CtlBusy1 = 6'b101000;
  localparam logic [5:0] CtlDone0 = 6'b010010;
  localparam logic [5:0] CtlDone1 = 6'b100100;
  localparam logic [5:0] CtlErr0  = 6'b010011;

  bus_arbiter #(.TIMEOUT(TO), .AW(AW), .DW(DW)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .req0           (req0),
    .req1           (req1),
    .wr_rd0         (wr_rd0),
    .wr_rd1         (wr_rd1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .ack1           (ack1),
    .err            (err),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .bus_valid      (bus_valid),
    .wr_rd          (wr_rd),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .ext_sel        (ext_sel),
    .ext_ack        (ext_ack)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; wr_rd0 = 0; wr_rd1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ext_sel = 0; ext_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0 = 1; req1 = 1; addr0 = 32'h1234; wdata0 = 32'h5678; wr_rd0 = 1;
    Rst = 1;
    tick();
    tick();
    checks++;
    if (ctl !== CtlIdle) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CtlIdle);
    end
    checks++;
    if ({wr_rd, ADDR, Data_BUS_WRITE} !== '0) begin
      errors++; $display("FAIL reset_bus: got wr_rd=%b ADDR=%h DATA=%h want all 0",
                         wr_rd, ADDR, Data_BUS_WRITE);
    end
    idle_inputs();
    Rst = 0;
    tick();
  endtask

  task automatic test_internal_read();
    req0 = 1; addr0 = 32'h10; wr_rd0 = 0; ext_sel = 0;
    tick();
    checks++;
    if ({ctl, wr_rd, ADDR} !== {CtlBusy0, 1'b0, 32'h10}) begin
      errors++; $display("FAIL int_read_busy: got ctl=%b wr_rd=%b ADDR=%h want %b 0 00000010",
                         ctl, wr_rd, ADDR, CtlBusy0);
    end
    tick();
    checks++;
    if (ctl !== CtlDone0) begin
      errors++; $display("FAIL int_read_ack: got %b want %b", ctl, CtlDone0);
    end
    req0 = 0;
    tick();
    checks++;
    if (ctl !== CtlIdle) begin
      errors++; $display("FAIL int_read_idle: got %b want %b", ctl, CtlIdle);
    end
  endtask

  task automatic test_tie();
    logic [5:0] exp_busy, exp_done;
    Rst = 1;
    tick();
    Rst = 0;
    req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0; ext_sel = 0;
    for (int i = 0; i < 4; i++) begin
      exp_busy = (i % 2 == 0) ? CtlBusy0 : CtlBusy1;
      exp_done = (i % 2 == 0) ? CtlDone0 : CtlDone1;
      tick();
      checks++;
      if ({ctl, ADDR} !== {exp_busy, ((i % 2 == 0) ? 32'hA0 : 32'hB0)}) begin
        errors++; $display("FAIL tie_grant%0d: got ctl=%b ADDR=%h want ctl=%b", i, ctl, ADDR,
                           exp_busy);
      end
      tick();
      checks++;
      if (ctl !== exp_done) begin
        errors++; $display("FAIL tie_ack%0d: got %b want %b", i, ctl, exp_done);
      end
      tick();
      checks++;
      if (ctl !== CtlIdle) begin
        errors++; $display("FAIL tie_idle%0d: got %b want %b", i, ctl, CtlIdle);
      end
    end
    idle_inputs();
  endtask

  task automatic test_ext_write();
    req1 = 1; wr_rd1 = 1; wdata1 = 32'hDEADBEEF; addr1 = 32'h8000_0000; ext_sel = 1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({ctl, wr_rd, Data_BUS_WRITE} !== {CtlBusy1, 1'b1, 32'hDEADBEEF}) begin
        errors++; $display("FAIL ext_write_busy%0d: got ctl=%b wr_rd=%b DATA=%h want %b 1 deadbeef",
                           i, ctl, wr_rd, Data_BUS_WRITE, CtlBusy1);
      end
      if (i == 4) ext_ack = 1;
      tick();
    end
    checks++;
    if (ctl !== CtlDone1) begin
      errors++; $display("FAIL ext_write_ack: got %b want %b", ctl, CtlDone1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout(input bit late_ack);
    req0 = 1; addr0 = 32'h9000; ext_sel = 1; ext_ack = 0;
    tick();
    for (int n = 1; n <= int'(TO); n++) begin
      checks++;
      if (ctl !== CtlBusy0) begin
        errors++; $display("FAIL timeout_busy%0d (late_ack=%0d): got %b want %b", n, late_ack,
                           ctl, CtlBusy0);
      end
      if (n == int'(TO) && late_ack) ext_ack = 1;
      tick();
    end
    checks++;
    if (ctl !== CtlErr0) begin
      errors++; $display("FAIL timeout_err (late_ack=%0d): got %b want %b", late_ack, ctl, CtlErr0);
    end
    idle_inputs();
    tick();
    checks++;
    if (ctl !== CtlIdle) begin
      errors++; $display("FAIL timeout_idle: got %b want %b", ctl, CtlIdle);
    end
  endtask

  task automatic test_reset_mid();
    req1 = 1; addr1 = 32'hC0; wdata1 = 32'h1111_2222; wr_rd1 = 1; ext_sel = 1;
    tick();
    tick();
    checks++;
    if (ctl !== CtlBusy1) begin
      errors++; $display("FAIL rst_mid_busy2: got %b want %b", ctl, CtlBusy1);
    end
    Rst = 1;
    tick();
    checks++;
    if ({ctl, wr_rd, ADDR, Data_BUS_WRITE} !== '0) begin
      errors++; $display("FAIL rst_mid_clear: got ctl=%b wr_rd=%b ADDR=%h DATA=%h want all 0",
                         ctl, wr_rd, ADDR, Data_BUS_WRITE);
    end
    Rst = 0;
    idle_inputs();
    tick();
    checks++;
    if (ctl !== CtlIdle) begin
      errors++; $display("FAIL rst_mid_noack: got %b want %b", ctl, CtlIdle);
    end
  endtask

  task automatic test_operand_change();
    req0 = 1; addr0 = 32'h44; wdata0 = 32'h55; wr_rd0 = 1; ext_sel = 1;
    tick();
    addr0 = 32'h88; wdata0 = 32'h99; wr_rd0 = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ctl, wr_rd, ADDR, Data_BUS_WRITE} !== {CtlBusy0, 1'b1, 32'h44, 32'h55}) begin
        errors++; $display("FAIL operand_hold%0d: got ctl=%b wr_rd=%b ADDR=%h DATA=%h want 44/55",
                           i, ctl, wr_rd, ADDR, Data_BUS_WRITE);
      end
    end
    ext_ack = 1;
    tick();
    checks++;
    if (ctl !== CtlDone0) begin
      errors++; $display("FAIL operand_ack: got %b want %b", ctl, CtlDone0);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    Rst = 1;
    test_reset();
    test_internal_read();
    test_tie();
    test_ext_write();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_operand_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
